clk_period_monitor: RTL
=======================

Name: clk_period_monitor

Overview:
- Sits downstream of the clock-select/glitch-free switching stage and consumes its switched output clock as a sampled data signal.
- Measures high time, low time and period of that clock in clk_in cycles.
- Compares the period against an expected value with tolerance and reports the absolute duty imbalance.
- Flags a stopped clock, so the switch controller and bench can confirm a selected source is the one actually present.

Parameters:
- CNT_W, 16, width of the time counters and measurement outputs.
- TIMEOUT, 1024, clk_in cycles without a monitored edge before stuck asserts; must be < 2^CNT_W.

Ports:
- clk_in  input  1  system sampling clock; all logic on its rising edge
- reset  input  1  asynchronous, active-low reset
- mon_clk  input  1  monitored (switched) clock, asynchronous to clk_in
- enable  input  1  1 = measure; 0 = return to IDLE
- clear  input  1  one-cycle pulse; clears sticky freq_err
- expected_period  input  CNT_W  nominal period in clk_in cycles
- tol_cycles  input  CNT_W  allowed |period - expected_period|
- high_time  output  CNT_W  last measured high time
- low_time  output  CNT_W  last measured low time
- period  output  CNT_W  last measured period, saturating high_time+low_time
- duty_diff  output  CNT_W  |high_time - low_time| of last measurement
- meas_valid  output  1  one-cycle pulse when the outputs above update
- in_tol  output  1  last measurement within tolerance
- freq_err  output  1  sticky: any out-of-tolerance measurement or stuck event
- stuck  output  1  no mon_clk edge for TIMEOUT cycles

Behaviour:
- Reset (reset=0, asynchronous): every output 0, all counters 0, synchronizer flops 0, FSM = IDLE.
- Input path: 2-flop synchronizer s1->s2, then s3 = previous s2.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - mon_clk change to edge detect is 2 clk_in cycles; to meas_valid is 3 clk_in edges.
- FSM:
  - IDLE: enable=1 -> WAIT_RISE.
  - WAIT_RISE: discards the partial first phase. On rise -> HIGH, hi_cnt<=1.
  - HIGH: hi_cnt++ each cycle. On fall -> LOW, lo_cnt<=1.
  - LOW: lo_cnt++ each cycle. On rise, in one cycle:
    - latch high_time=hi_cnt, low_time=lo_cnt, period=sat(hi_cnt+lo_cnt), duty_diff=|hi_cnt-lo_cnt|;
    - meas_valid=1 on the following cycle;
    - hi_cnt<=1, go to HIGH.
  - The first valid measurement is at the second synchronized rise.
- Counters, period and duty_diff saturate at 2^CNT_W-1 and never wrap. Sums and differences use CNT_W+1-bit intermediates.
- Tolerance check: in_tol updates together with meas_valid.
  - Condition: in_tol = (|period - expected_period| <= tol_cycles), compared at CNT_W+1 bits.
  - in_tol=0 sets freq_err.
- Timeout:
  - idle_cnt resets on any rise or fall and increments otherwise in WAIT_RISE/HIGH/LOW.
  - When idle_cnt reaches TIMEOUT: stuck<=1, freq_err<=1, FSM -> WAIT_RISE, hi_cnt/lo_cnt cleared.
  - stuck stays 1 until the next meas_valid, then clears.
- freq_err: sticky. clear deasserts it, but a set condition in the same cycle as clear wins, so freq_err stays 1.
- enable=0 in any state:
  - FSM -> IDLE next cycle; hi_cnt, lo_cnt and idle_cnt zeroed; meas_valid=0.
  - high_time, low_time, period, duty_diff, in_tol and freq_err hold; stuck clears.
- Reset mid-measurement aborts immediately. No partial result is ever reported.
- Simultaneous rise and timeout cannot occur: an edge resets idle_cnt in that cycle, so the edge takes priority.

Test Plan:
- Reset: reset=0 while measuring with mon_clk toggling -> all outputs 0 within the same cycle. Release; first meas_valid only after two synchronized rises.
- Nominal: mon_clk period 10 clk_in cycles, 5 high/5 low; expected_period=10, tol_cycles=0 -> period=10, high_time=5, low_time=5, duty_diff=0, in_tol=1, freq_err=0, meas_valid one cycle wide every 10 cycles.
- Out of tolerance: period 12 (8 high/4 low), expected_period=10, tol_cycles=1 -> period=12, duty_diff=4, in_tol=0, freq_err=1. Then period 11 -> in_tol=1, freq_err remains 1 until clear.
- Stuck: TIMEOUT=64, mon_clk held high after a rise -> stuck=1 and freq_err=1 exactly 64 cycles after the last synchronized edge. Resume a period-10 clock -> stuck=0 at the first meas_valid.
- Saturation: CNT_W=4, mon_clk 12 high/8 low -> high_time=12, low_time=8, period=15, duty_diff=4; no wrap.
- clear collision: assert clear in the same cycle an out-of-tolerance meas_valid sets freq_err -> freq_err=1. A lone clear one cycle later -> freq_err=0.

Source files
------------

// File: rtl/clk_period_monitor.sv
// Measures high time, low time and period of an asynchronous monitored clock in clk_in cycles,
// checks the period against an expected value and flags a stopped clock.
module clk_period_monitor #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             mon_clk,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] expected_period,
  input  logic [CNT_W-1:0] tol_cycles,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] low_time,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] duty_diff,
  output logic             meas_valid,
  output logic             in_tol,
  output logic             freq_err,
  output logic             stuck
);

  localparam int unsigned      EXT_W     = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } state_t;

  state_t           state, state_d;
  logic             s1, s2, s3;
  logic             rise, fall, any_edge, timeout;

  logic [CNT_W-1:0] hi_cnt, hi_d;
  logic [CNT_W-1:0] lo_cnt, lo_d;
  logic [CNT_W-1:0] idle_cnt, idle_d;
  logic [CNT_W-1:0] hi_inc, lo_inc;

  logic [EXT_W-1:0] sum_ext;
  logic [EXT_W-1:0] hl_diff_ext;
  logic [EXT_W-1:0] per_err_ext;
  logic [CNT_W-1:0] per_sat;
  logic [CNT_W-1:0] duty_sat;
  logic             meas_in_tol;

  logic [CNT_W-1:0] high_d, low_d, period_d, duty_d;
  logic             mv_d, in_tol_d, ferr_d, stuck_d, ferr_set;

  // Two-flop synchronizer plus one history flop for edge detection
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= mon_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise     = s2 & ~s3;
  assign fall     = ~s2 & s3;
  assign any_edge = rise | fall;
  assign timeout  = ~any_edge && (idle_cnt == IDLE_LAST);

  assign hi_inc = (hi_cnt == CNT_MAX) ? hi_cnt : hi_cnt + CNT_ONE;
  assign lo_inc = (lo_cnt == CNT_MAX) ? lo_cnt : lo_cnt + CNT_ONE;

  // Result arithmetic on the counters as they stand in the closing-rise cycle
  assign sum_ext     = {1'b0, hi_cnt} + {1'b0, lo_cnt};
  assign per_sat     = sum_ext[CNT_W] ? CNT_MAX : sum_ext[CNT_W-1:0];
  assign hl_diff_ext = (hi_cnt >= lo_cnt) ? ({1'b0, hi_cnt} - {1'b0, lo_cnt})
                                          : ({1'b0, lo_cnt} - {1'b0, hi_cnt});
  assign duty_sat    = hl_diff_ext[CNT_W] ? CNT_MAX : hl_diff_ext[CNT_W-1:0];
  assign per_err_ext = (per_sat >= expected_period)
                       ? ({1'b0, per_sat} - {1'b0, expected_period})
                       : ({1'b0, expected_period} - {1'b0, per_sat});
  assign meas_in_tol = (per_err_ext <= {1'b0, tol_cycles});

  // Next-state and next-output logic
  always_comb begin
    state_d  = state;
    hi_d     = hi_cnt;
    lo_d     = lo_cnt;
    idle_d   = idle_cnt;
    high_d   = high_time;
    low_d    = low_time;
    period_d = period;
    duty_d   = duty_diff;
    in_tol_d = in_tol;
    stuck_d  = stuck;
    mv_d     = 1'b0;
    ferr_set = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      hi_d    = '0;
      lo_d    = '0;
      idle_d  = '0;
      stuck_d = 1'b0;
    end else begin
      idle_d = any_edge ? '0 : idle_cnt + CNT_ONE;

      case (state)
        IDLE: begin
          state_d = WAIT_RISE;
          idle_d  = '0;
        end
        WAIT_RISE: begin
          if (rise) begin
            state_d = HIGH;
            hi_d    = CNT_ONE;
          end
        end
        HIGH: begin
          if (fall) begin
            state_d = LOW;
            lo_d    = CNT_ONE;
          end else begin
            hi_d = hi_inc;
          end
        end
        LOW: begin
          if (rise) begin
            high_d   = hi_cnt;
            low_d    = lo_cnt;
            period_d = per_sat;
            duty_d   = duty_sat;
            in_tol_d = meas_in_tol;
            ferr_set = ~meas_in_tol;
            stuck_d  = 1'b0;
            mv_d     = 1'b1;
            hi_d     = CNT_ONE;
            lo_d     = '0;
            state_d  = HIGH;
          end else begin
            lo_d = lo_inc;
          end
        end
        default: state_d = IDLE;
      endcase

      // An edge clears idle_cnt in the same cycle, so timeout never races a latch
      if (timeout && (state != IDLE)) begin
        stuck_d  = 1'b1;
        ferr_set = 1'b1;
        state_d  = WAIT_RISE;
        hi_d     = '0;
        lo_d     = '0;
        idle_d   = '0;
      end
    end

    if (ferr_set) begin
      ferr_d = 1'b1;
    end else if (clear) begin
      ferr_d = 1'b0;
    end else begin
      ferr_d = freq_err;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      hi_cnt     <= '0;
      lo_cnt     <= '0;
      idle_cnt   <= '0;
      high_time  <= '0;
      low_time   <= '0;
      period     <= '0;
      duty_diff  <= '0;
      meas_valid <= 1'b0;
      in_tol     <= 1'b0;
      freq_err   <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      state      <= state_d;
      hi_cnt     <= hi_d;
      lo_cnt     <= lo_d;
      idle_cnt   <= idle_d;
      high_time  <= high_d;
      low_time   <= low_d;
      period     <= period_d;
      duty_diff  <= duty_d;
      meas_valid <= mv_d;
      in_tol     <= in_tol_d;
      freq_err   <= ferr_d;
      stuck      <= stuck_d;
    end
  end

endmodule
